// File: rtl/if_id_stage_pkg.sv
// Shared widths, instruction field positions and the decoded-field bundle
// used by the IF/ID pipeline register.
package if_id_stage_pkg;

  localparam int WORD_LEN        = 32;
  localparam int SIGN_EXTEND_LEN = 16;

  localparam int OPCODE_HI  = 31;
  localparam int OPCODE_LO  = 26;
  localparam int RS_HI      = 25;
  localparam int RS_LO      = 21;
  localparam int RT_HI      = 20;
  localparam int RT_LO      = 16;
  localparam int RD_HI      = 15;
  localparam int RD_LO      = 11;
  localparam int SHAMT_HI   = 10;
  localparam int SHAMT_LO   = 6;
  localparam int FUNCT_HI   = 5;
  localparam int FUNCT_LO   = 0;
  localparam int IMM_HI     = 15;
  localparam int IMM_LO     = 0;
  localparam int JTARGET_HI = 25;
  localparam int JTARGET_LO = 0;

  typedef struct packed {
    logic [5:0]                 opcode;
    logic [4:0]                 rs;
    logic [4:0]                 rt;
    logic [4:0]                 rd;
    logic [4:0]                 shamt;
    logic [5:0]                 funct;
    logic [SIGN_EXTEND_LEN-1:0] imm;
    logic [25:0]                jtarget;
  } instr_fields_t;

endpackage

// File: rtl/if_id_stage_instr_fields.sv
// Purely combinational MIPS instruction slicer: word in, every field out.
import if_id_stage_pkg::*;

module instr_fields (
  input  logic [WORD_LEN-1:0] instr_i,
  output instr_fields_t       fields_o
);

  always_comb begin
    fields_o.opcode  = instr_i[OPCODE_HI:OPCODE_LO];
    fields_o.rs      = instr_i[RS_HI:RS_LO];
    fields_o.rt      = instr_i[RT_HI:RT_LO];
    fields_o.rd      = instr_i[RD_HI:RD_LO];
    fields_o.shamt   = instr_i[SHAMT_HI:SHAMT_LO];
    fields_o.funct   = instr_i[FUNCT_HI:FUNCT_LO];
    fields_o.imm     = instr_i[IMM_HI:IMM_LO];
    fields_o.jtarget = instr_i[JTARGET_HI:JTARGET_LO];
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: main entry drives the decode outputs, a one-entry
// skid entry absorbs the instruction in flight while decode is stalled.
import if_id_stage_pkg::*;

module if_id_stage (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_LEN-1:0]        in_pc,
  input  logic [WORD_LEN-1:0]        in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_LEN-1:0]        out_pc_plus4,
  output logic [WORD_LEN-1:0]        out_instr,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [SIGN_EXTEND_LEN-1:0] out_imm,
  output logic [25:0]                out_jtarget
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // sender holds its data stable until then, and ready never depends on valid.
  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [WORD_LEN-1:0] main_instr_q, main_instr_d;
  logic [WORD_LEN-1:0] main_pc4_q, main_pc4_d;
  logic [WORD_LEN-1:0] skid_instr_q, skid_instr_d;
  logic [WORD_LEN-1:0] skid_pc4_q, skid_pc4_d;
  logic                accept;
  logic                consume;
  logic [WORD_LEN-1:0] in_pc4;
  instr_fields_t       fields;

  assign in_ready = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  assign in_pc4 = in_pc + WORD_LEN'(4);

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_instr_d = main_instr_q;
    main_pc4_d   = main_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        main_instr_d = skid_instr_q;
        main_pc4_d   = skid_pc4_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      main_valid_d = accept;
      if (accept) begin
        main_instr_d = in_instr;
        main_pc4_d   = in_pc4;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc4_d   = in_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_instr_q <= '0;
      main_pc4_q   <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_instr_q <= main_instr_d;
      main_pc4_q   <= main_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Stale data after a flush is masked so an empty stage always shows a NOP.
  assign out_instr    = main_valid_q ? main_instr_q : '0;
  assign out_pc_plus4 = main_valid_q ? main_pc4_q : '0;

  instr_fields u_instr_fields (
    .instr_i  (out_instr),
    .fields_o (fields)
  );

  assign out_opcode  = fields.opcode;
  assign out_rs      = fields.rs;
  assign out_rt      = fields.rt;
  assign out_rd      = fields.rd;
  assign out_shamt   = fields.shamt;
  assign out_funct   = fields.funct;
  assign out_imm     = fields.imm;
  assign out_jtarget = fields.jtarget;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random traffic
// checked every cycle against an in-order two-slot queue model.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm;
  logic [25:0] out_jtarget;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } item_t;

  item_t mq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  if_id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc_plus4 (out_pc_plus4),
    .out_instr    (out_instr),
    .out_opcode   (out_opcode),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_shamt    (out_shamt),
    .out_funct    (out_funct),
    .out_imm      (out_imm),
    .out_jtarget  (out_jtarget)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected view: the stage behaves as an ordered buffer of at most two items.
  task automatic check_all();
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ev;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].instr : 32'h0;
    ep = ev ? mq[0].pc4 : 32'h0;
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, ev});
    check_eq("out_instr", out_instr, ei);
    check_eq("out_pc_plus4", out_pc_plus4, ep);
    check_eq("out_opcode", {26'b0, out_opcode}, {26'b0, ei[31:26]});
    check_eq("out_rs", {27'b0, out_rs}, {27'b0, ei[25:21]});
    check_eq("out_rt", {27'b0, out_rt}, {27'b0, ei[20:16]});
    check_eq("out_rd", {27'b0, out_rd}, {27'b0, ei[15:11]});
    check_eq("out_shamt", {27'b0, out_shamt}, {27'b0, ei[10:6]});
    check_eq("out_funct", {26'b0, out_funct}, {26'b0, ei[5:0]});
    check_eq("out_imm", {16'b0, out_imm}, {16'b0, ei[15:0]});
    check_eq("out_jtarget", {6'b0, out_jtarget}, {6'b0, ei[25:0]});
  endtask

  // driver: apply one cycle of inputs, advance the model, check at negedge
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic ordy, input logic r);
    int  sz;
    logic acc;
    logic cons;
    in_valid = v;
    in_pc = pc;
    in_instr = instr;
    flush = fl;
    out_ready = ordy;
    rst = r;
    sz = mq.size();
    acc = v && (sz < 2);
    cons = (sz > 0) && ordy;
    @(posedge clk);
    if (r || fl) begin
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back('{pc4: pc + 32'd4, instr: instr});
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    in_valid = 0; in_pc = 0; in_instr = 0; flush = 0; out_ready = 0; rst = 1;
    @(negedge clk);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);

    // stream with out_ready held high
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0040_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      check_eq("stream_pc4", out_pc_plus4, 32'h0040_0004 + 32'(4 * i));
    end
    idle(1'b1);
    check_eq("stream_drained", {31'b0, out_valid}, 32'd0);

    // stall: A held, B into skid, then release
    step(1'b1, 32'h0000_1000, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_2000, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
    check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("stall_hold_a", out_instr, 32'hAAAA_0001);
    step(1'b1, 32'h0000_3000, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check_eq("stall_then_b", out_instr, 32'hBBBB_0002);
    idle(1'b1);
    check_eq("stall_empty", {31'b0, out_valid}, 32'd0);

    // flush with both entries full and a new input presented
    step(1'b1, 32'h0000_4000, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_5000, 32'h2222_0002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_6000, 32'h3333_0003, 1'b1, 1'b1, 1'b0);
    check_eq("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("flush_out_instr", out_instr, 32'h0);
    idle(1'b1);
    check_eq("flush_dropped", {31'b0, out_valid}, 32'd0);

    // field decode
    step(1'b1, 32'h0000_7000, 32'h8C48_FFFC, 1'b0, 1'b0, 1'b0);
    check_eq("lw_opcode", {26'b0, out_opcode}, 32'h23);
    check_eq("lw_rs", {27'b0, out_rs}, 32'd2);
    check_eq("lw_rt", {27'b0, out_rt}, 32'd8);
    check_eq("lw_imm", {16'b0, out_imm}, 32'hFFFC);
    step(1'b1, 32'h0000_7004, 32'h0109_502A, 1'b0, 1'b1, 1'b0);
    check_eq("slt_rd", {27'b0, out_rd}, 32'd10);
    check_eq("slt_funct", {26'b0, out_funct}, 32'h2A);
    idle(1'b1);

    // pc wrap
    step(1'b1, 32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
    check_eq("wrap_valid", {31'b0, out_valid}, 32'd1);
    check_eq("wrap_pc4", out_pc_plus4, 32'h0);
    idle(1'b1);

    // reset mid-stall with both entries full
    step(1'b1, 32'h0000_8000, 32'h4444_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_9000, 32'h5555_0002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_A000, 32'h6666_0003, 1'b1, 1'b1, 1'b1);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_pc4", out_pc_plus4, 32'h0);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 79) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
